// File: rtl/imem_responder.sv
// Instruction-memory responder: captures a fetch read request, waits LATENCY
// cycles, then returns the addressed word with ready held until enable drops.
module imem_responder #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 1024,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] ERR_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_enable,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_ready,
    output logic              rd_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [31:0]       rd_count
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic [31:0]         count_q, count_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                rd_bad;
    logic [AW-1:0]       rd_idx;
    logic                ld_ok;
    logic [AW-1:0]       ld_idx;
    logic                ld_unused;

    assign rd_idx    = addr_q[AW+1:2];
    assign rd_bad    = (addr_q[1:0] != 2'b00) || (addr_q[ADDR_W-1:AW+2] != '0);
    assign ld_idx    = ld_addr[AW+1:2];
    assign ld_ok     = (ld_addr[ADDR_W-1:AW+2] == '0);
    assign ld_unused = ^ld_addr[1:0];

    // No reset on the store: the program image survives a core reset.
    // Nonblocking write gives read-before-write against the response read.
    always_ff @(posedge clk) begin
        if (ld_en && ld_ok) mem_q[ld_idx] <= ld_data;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        ready_d = ready_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (rd_enable) begin
                    addr_d  = rd_addr;
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!rd_enable) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    data_d  = rd_bad ? DATA_W'(ERR_WORD) : mem_q[rd_idx];
                    err_d   = rd_bad;
                    ready_d = 1'b1;
                    count_d = count_q + 32'd1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (!rd_enable) begin
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    assign rd_data  = data_q;
    assign rd_ready = ready_q;
    assign rd_err   = err_q;
    assign rd_count = count_q;
endmodule

// File: doc/imem_responder.md
# imem_responder

- Instruction-memory responder: the memory side of the fetch read handshake (`mem_rd_addr` / `mem_rd_enable` / `mem_rd_data` / `mem_rd_ready`).
- Captures a word-aligned read request, inserts a programmable number of wait states, then returns the addressed instruction word with a ready level held until the requester drops enable.
- A side load port preloads the program image.
- Sits between the fetch stage and the backing instruction store in both simulation and FPGA builds.

## Interface
Parameters:
- `ADDR_W`, 32: request address width.
- `DATA_W`, 32: instruction word width.
- `DEPTH`, 1024: number of words (power of two, ≥ 2).
- `LATENCY`, 2: wait cycles from request capture to ready (1..15).
- `ERR_WORD`, 32'h0000_0013: word returned on a bad address (NOP).

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `rd_addr`  in  ADDR_W  byte address of requested instruction
- `rd_enable`  in  1  request level from fetch
- `rd_data`  out  DATA_W  returned instruction word
- `rd_ready`  out  1  response valid; held while `rd_enable` stays high
- `rd_err`  out  1  qualifies `rd_data` as `ERR_WORD` (misaligned / out of range)
- `ld_en`  in  1  load-port write strobe
- `ld_addr`  in  ADDR_W  load byte address (word-aligned)
- `ld_data`  in  DATA_W  load word
- `rd_count`  out  32  completed responses since reset, wraps

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, `rd_enable`=1 sampled:
  - Capture `rd_addr` into `addr_q`.
  - Load the wait counter with `LATENCY`-1.
  - Go to WAIT.
- WAIT:
  - If `rd_enable`=0 (requester flush/abort): go to IDLE; no response, `rd_count` unchanged.
  - Otherwise decrement the counter. At 0, register the response (`rd_data`, `rd_err`, `rd_ready`=1), increment `rd_count`, go to RESP.
- RESP:
  - Hold `rd_ready`, `rd_data` and `rd_err` stable while `rd_enable`=1.
  - When `rd_enable`=0 is sampled: `rd_ready`←0, `rd_err`←0, go to IDLE. `rd_data` keeps its last value.
- Address decode:
  - Word index = `addr_q`[log2(DEPTH)+1:2].
  - Bad if `addr_q`[1:0]≠0 or `addr_q` ≥ 4·DEPTH. A bad address gives `rd_data`=`ERR_WORD` and `rd_err`=1.
- `rd_addr` changes after capture are ignored until the next IDLE capture.
- Load port:
  - `ld_en` writes `ld_data` to the word at `ld_addr` in any state. `ld_addr`[1:0] is ignored.
  - Out-of-range loads are dropped.
  - A same-cycle load to the word being read returns the old data (read-before-write).
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE; `rd_ready`=0, `rd_data`=0, `rd_err`=0, `rd_count`=0, wait counter 0.
- Reset in WAIT or RESP aborts the transaction; no response is produced.
- Request sampled high at edge E0: `rd_ready` is high after edge E(LATENCY). With `LATENCY`=1, ready rises one cycle after capture.
- Release: `rd_enable` sampled low at edge Er gives `rd_ready` low after Er.
- Minimum gap between responses: a new request is capturable at edge Er+1 at the earliest.
- Back-to-back request period: `LATENCY`+2 cycles.
- `rd_enable` held high continuously keeps one response asserted. A second transaction requires `rd_enable` to be low for at least one sampled edge.
- `rd_count` increments on the edge that sets `rd_ready`, wrapping 0xFFFF_FFFF→0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles; `rd_enable`=0 throughout → `rd_ready` stays 0.
- Load word 0x10 = 32'hDEADBEEF; request `rd_addr`=0x10 with `LATENCY`=2 → `rd_ready` rises exactly 2 cycles after capture with data DEADBEEF and `rd_err`=0, held while enable high; `rd_count`=1.
- Fetch-style loop: 8 sequential requests at 0,4,…,0x1C, each dropping enable one cycle after ready → data matches the preloaded image; period 4 cycles; `rd_count`=8.
- Abort: enable high for 1 cycle in WAIT then low → no `rd_ready`; `rd_count` unchanged; the next request at 0x8 returns the correct word.
- Bad addresses: `rd_addr`=0x6 and `rd_addr`=4·DEPTH → `rd_data`=0x00000013 and `rd_err`=1; `rd_err` clears when enable drops.
- Mid-transaction events:
  - Reset asserted in RESP → `rd_ready` is 0 after that edge and `rd_count`=0.
  - `rd_addr` changed during WAIT → the originally captured word is returned.
